prores_block_scan_ctrl: RTL
===========================

Name: prores_block_scan_ctrl

Overview:
- Sequencer between the quantiser (`pre_quant_qt_qscale`) and the entropy coders (DC, AC run, AC level).
- Accepts one quantised 8x8 block via valid/ready.
- Emits the DC coefficient, then walks the 63 AC coefficients in ProRes progressive scan order and emits one (run, level) pair per nonzero coefficient.
- Handles back-pressure from the VLC stage and signals end of block.

Parameters:
- IN_W, 32, width of each signed input coefficient.
- OUT_W, 20, width of signed DC/level outputs; saturating clip from IN_W.
- RUN_W, 6, width of the run count (max 62).

Ports:
- CLOCK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- BLK_VALID  in  1  input block valid.
- BLK_READY  out  1  controller can accept a block (registered).
- BLK_DATA  in  IN_W x [8][8]  quantised block, [row][col], signed; sampled only on accept.
- FIRST_BLK  in  1  block is first of a slice; sampled on accept.
- OUT_READY  in  1  downstream accepts the current DC or AC word.
- DC_VALID  out  1  DC_DATA valid.
- DC_DATA  out  OUT_W  saturated block[0][0].
- DC_FIRST  out  1  qualifies DC_VALID; downstream resets its DC predictor.
- AC_VALID  out  1  AC pair valid.
- AC_RUN  out  RUN_W  count of zero coefficients preceding this level in scan order.
- AC_LEVEL  out  OUT_W  saturated nonzero coefficient.
- BLK_DONE  out  1  one-cycle pulse, block fully scanned and all words accepted.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (async, RESET=1): state=IDLE; BLK_READY, DC_VALID, DC_FIRST, AC_VALID, BLK_DONE, BUSY=0; DC_DATA, AC_RUN, AC_LEVEL=0; p=0, run=0.
  - First rising edge after RESET falls sets BLK_READY=1.
  - Reset mid-block discards the captured block; no BLK_DONE is issued.
- Accept: BLK_VALID & BLK_READY at edge.
  - Capture BLK_DATA and FIRST_BLK.
  - BLK_READY<=0, state<=DC, DC_VALID<=1.
  - DC_DATA<=sat(blk[0][0]), DC_FIRST<=FIRST_BLK.
- Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. For OUT_W=20 the range is [-524288, 524287].
- DC state:
  - Outputs are held stable while !OUT_READY.
  - On OUT_READY: DC_VALID<=0, DC_FIRST<=0, p<=1, run<=0, state<=AC.
- Scan table: ProRes progressive scan, index = row*8+col, positions 0..63: 0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63.
- AC state: advances on each edge where (!AC_VALID | OUT_READY). Let c = blk[scan[p]].
  - If c != 0: AC_VALID<=1, AC_RUN<=run, AC_LEVEL<=sat(c), run<=0.
  - If c == 0: AC_VALID<=0, run<=run+1.
  - p<=p+1; when p==63 is processed, state<=DONE.
  - When AC_VALID & !OUT_READY: p, run and the outputs all hold.
- Throughput: with OUT_READY held at 1, one coefficient per cycle.
- DONE state:
  - Wait until !AC_VALID, or AC_VALID & OUT_READY (that edge clears AC_VALID).
  - Then pulse BLK_DONE for 1 cycle, set BLK_READY<=1, state<=IDLE.
  - Trailing zeros produce no AC word.
  - An all-zero AC block produces only the DC word and BLK_DONE.
- Latency, accept at edge 0 with OUT_READY=1:
  - DC_VALID high in cycle 1.
  - First AC pair visible in cycle 3 at the earliest.
  - BLK_DONE in cycle 66.
  - BLK_READY high in cycle 67.
- Run width: run never exceeds 62, so it cannot wrap.
- Precedence: BLK_VALID is ignored whenever BLK_READY=0; there is no overlap of blocks. RESET overrides every other event.

Test Plan:
- All-zero block except blk[0][0]=100, FIRST_BLK=1, OUT_READY=1 -> DC_VALID cycle 1 with DC_DATA=100, DC_FIRST=1; no AC_VALID; BLK_DONE cycle 66; BLK_READY cycle 67.
- blk[0][1]=5, blk[1][0]=-3, blk[7][7]=7 (scan positions 1, 2, 63) -> AC pairs (0,5), (0,-3), (60,7) in order, then BLK_DONE.
- Saturation: blk[0][0]=1000000, blk[0][1]=-2000000 -> DC_DATA=524287, AC_LEVEL=-524288.
- Back-pressure: same block as scenario 2, OUT_READY low for 4 cycles at each VALID -> DC and AC outputs held stable while low; identical pair sequence; BLK_DONE delayed by the stall total.
- Back-to-back: BLK_VALID held high with two blocks -> second accept on the edge after BLK_READY rises; its DC_FIRST follows its own FIRST_BLK.
- RESET asserted mid-AC scan (after 2 pairs) -> all outputs 0 immediately; no BLK_DONE; BLK_READY=1 one edge after release; next block scans correctly.

Source files
------------

// File: rtl/prores_block_scan_ctrl.sv
// ProRes block scan controller: captures one quantised 8x8 block and emits its DC word.
// It then walks the 63 AC coefficients in progressive scan order and emits one (run, level) pair per nonzero.
module prores_block_scan_ctrl #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 20,
    parameter int RUN_W = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [7:0][7:0][IN_W-1:0] blk_data,
    input  logic                      first_blk,
    input  logic                      out_ready,
    output logic                      dc_valid,
    output logic signed [OUT_W-1:0]   dc_data,
    output logic                      dc_first,
    output logic                      ac_valid,
    output logic [RUN_W-1:0]          ac_run,
    output logic signed [OUT_W-1:0]   ac_level,
    output logic                      blk_done,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DC,
        ST_AC,
        ST_DONE
    } state_t;

    // Progressive scan order, entries are row*8+col of the natural-order block.
    localparam int SCAN [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(64'sd1 <<< (OUT_W-1)));

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] x);
        if (x > SAT_MAX) begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end else if (x < SAT_MIN) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end
        return x[OUT_W-1:0];
    endfunction

    state_t                   state, state_n;
    logic                     blk_ready_n;
    logic                     dc_valid_n, dc_first_n;
    logic signed [OUT_W-1:0]  dc_data_n;
    logic                     ac_valid_n;
    logic [RUN_W-1:0]         ac_run_n;
    logic signed [OUT_W-1:0]  ac_level_n;
    logic                     blk_done_n;
    logic [5:0]               scan_pos, scan_pos_n;
    logic [RUN_W-1:0]         run, run_n;
    logic                     capture;
    logic signed [IN_W-1:0]   coef;
    logic signed [IN_W-1:0]   blk_q [64];

    assign busy = (state != ST_IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred; blocking '=' is correct in combinational logic.
    always_comb begin
        state_n     = state;
        blk_ready_n = blk_ready;
        dc_valid_n  = dc_valid;
        dc_first_n  = dc_first;
        dc_data_n   = dc_data;
        ac_valid_n  = ac_valid;
        ac_run_n    = ac_run;
        ac_level_n  = ac_level;
        blk_done_n  = 1'b0;
        scan_pos_n  = scan_pos;
        run_n       = run;
        capture     = 1'b0;
        coef        = blk_q[SCAN[scan_pos][5:0]];

        case (state)
            ST_IDLE: begin
                if (blk_ready && blk_valid) begin
                    capture     = 1'b1;
                    blk_ready_n = 1'b0;
                    state_n     = ST_DC;
                    dc_valid_n  = 1'b1;
                    dc_data_n   = sat(blk_data[0][0]);
                    dc_first_n  = first_blk;
                end else begin
                    blk_ready_n = 1'b1;
                end
            end

            ST_DC: begin
                if (out_ready) begin
                    dc_valid_n = 1'b0;
                    dc_first_n = 1'b0;
                    scan_pos_n = 6'd1;
                    run_n      = '0;
                    state_n    = ST_AC;
                end
            end

            // A pending AC pair that has not been taken freezes the walk.
            ST_AC: begin
                if (!ac_valid || out_ready) begin
                    if (coef != '0) begin
                        ac_valid_n = 1'b1;
                        ac_run_n   = run;
                        ac_level_n = sat(coef);
                        run_n      = '0;
                    end else begin
                        ac_valid_n = 1'b0;
                        run_n      = run + 1'b1;
                    end
                    scan_pos_n = scan_pos + 6'd1;
                    if (scan_pos == 6'd63) begin
                        state_n = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (!ac_valid || out_ready) begin
                    ac_valid_n = 1'b0;
                    blk_done_n = 1'b1;
                    state_n    = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            blk_ready <= 1'b0;
            dc_valid  <= 1'b0;
            dc_first  <= 1'b0;
            dc_data   <= '0;
            ac_valid  <= 1'b0;
            ac_run    <= '0;
            ac_level  <= '0;
            blk_done  <= 1'b0;
            scan_pos  <= '0;
            run       <= '0;
        end else begin
            state     <= state_n;
            blk_ready <= blk_ready_n;
            dc_valid  <= dc_valid_n;
            dc_first  <= dc_first_n;
            dc_data   <= dc_data_n;
            ac_valid  <= ac_valid_n;
            ac_run    <= ac_run_n;
            ac_level  <= ac_level_n;
            blk_done  <= blk_done_n;
            scan_pos  <= scan_pos_n;
            run       <= run_n;
        end
    end

    // NOTE: the block store has no reset; it is only read after a capture overwrites every entry.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    blk_q[r*8+c] <= blk_data[r][c];
                end
            end
        end
    end

endmodule
